// File: rtl/ram_reader_pkg.sv
// Shared types and buffer sizing for the RAM burst reader.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 4;
    localparam int BUF_AW    = 2;

endpackage

// File: rtl/ram_reader_buf.sv
// Four-entry FIFO holding RAM words until the consumer accepts them.
module ram_reader_buf
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [BUF_AW:0]   occupancy,
    output logic [WIDTH-1:0]  head_data
);

    logic [WIDTH-1:0]  mem_r [BUF_DEPTH];
    logic [BUF_AW-1:0] wr_ptr_r;
    logic [BUF_AW-1:0] rd_ptr_r;
    logic [BUF_AW:0]   count_r;
    logic              pop_s;

    // Pushes are never refused: the reader's credit rule keeps the FIFO from overflowing.
    assign pop_s = pop && (count_r != 3'd0);

    // Storage, pointers and occupancy count.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign occupancy = count_r;
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read engine: issues RAM read addresses under a credit limit and streams words out.
// Optional stall counter output enabled by RAM_BURST_READER_STALL_CNT_EN.
module ram_burst_reader
    import ram_reader_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Start,
    input  logic [AW-1:0]    i_Start_Addr,
    input  logic [AW:0]      i_Length,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [AW-1:0]    o_RAM_Addr,
    input  logic [WIDTH-1:0] i_RAM_Data,
    output logic             o_DV,
    output logic [WIDTH-1:0] o_Data,
    input  logic             i_Ready
`ifdef RAM_BURST_READER_STALL_CNT_EN
    ,output logic [15:0]     o_Stall_Count
`endif
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1'b1);

    state_t              state_r;
    state_t              state_s;
    logic [AW:0]         remain_r;
    logic [AW-1:0]       addr_r;
    logic                v1_r;
    logic                v2_r;
    logic                done_r;
    logic [BUF_AW:0]     occ_s;
    logic [BUF_AW+1:0]   pending_s;
    logic                start_s;
    logic                start_go_s;
    logic                issue_s;
    logic                pop_s;
    logic                last_pop_s;

    // Explicit wrap so non-power-of-two depths stay inside the RAM.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + ADDR_ONE;
    endfunction

    assign o_Busy     = (state_r != IDLE);
    assign start_s    = i_Start && !o_Busy;
    assign start_go_s = start_s && (i_Length != '0);
    assign pop_s      = o_DV && i_Ready;
    // v1_r: address registered, RAM not yet out; v2_r: RAM data valid, captured next edge.
    assign pending_s  = {1'b0, occ_s} + {3'b000, v1_r} + {3'b000, v2_r} - {3'b000, pop_s};
    assign issue_s    = (state_r == READ) && (remain_r != '0) && (pending_s < 4'd4);
    assign last_pop_s = (state_r == DRAIN) && pop_s && (occ_s == 3'd1) && !v1_r && !v2_r;

    // Next-state logic; the accepting start cycle issues the first address itself.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_go_s) begin
                    state_s = (i_Length == LEN_ONE) ? DRAIN : READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (issue_s && (remain_r == LEN_ONE)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (last_pop_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, address/length counters, in-flight pipeline and completion pulse.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r  <= IDLE;
            remain_r <= '0;
            addr_r   <= '0;
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (start_s && (i_Length == '0)) || last_pop_s;
            v1_r    <= start_go_s || issue_s;
            v2_r    <= v1_r;
            if (start_go_s) begin
                addr_r   <= i_Start_Addr;
                remain_r <= i_Length - LEN_ONE;
            end else if (issue_s) begin
                addr_r   <= next_addr(addr_r);
                remain_r <= remain_r - LEN_ONE;
            end
        end
    end

    assign o_RAM_Addr = addr_r;
    assign o_Done     = done_r;
    assign o_DV       = (occ_s != 3'd0);

    ram_reader_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .push      (v2_r),
        .push_data (i_RAM_Data),
        .pop       (pop_s),
        .occupancy (occ_s),
        .head_data (o_Data)
    );

`ifdef RAM_BURST_READER_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a word waits on the consumer.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            stall_cnt_r <= 16'd0;
        end else if (start_s) begin
            stall_cnt_r <= 16'd0;
        end else if (o_Busy && o_DV && !i_Ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign o_Stall_Count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with behavioural registered-output RAM models.
module tb_ram_burst_reader;

    logic       clk;
    logic       rst_n;

    logic       start, busy, done, dv, ready;
    logic [7:0] start_addr, ram_addr, ram_q, dout;
    logic [8:0] len;
    logic [7:0] ram [256];

    logic       s2_start, s2_busy, s2_done, s2_dv;
    logic [7:0] s2_start_addr, s2_ram_addr, s2_ram_q, s2_dout;
    logic [8:0] s2_len;
    logic [7:0] ram2 [200];

`ifdef RAM_BURST_READER_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] s2_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ram_burst_reader #(.WIDTH(8), .DEPTH(256)) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Start      (start),
        .i_Start_Addr (start_addr),
        .i_Length     (len),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_RAM_Addr   (ram_addr),
        .i_RAM_Data   (ram_q),
        .o_DV         (dv),
        .o_Data       (dout),
        .i_Ready      (ready)
`ifdef RAM_BURST_READER_STALL_CNT_EN
        ,.o_Stall_Count (stall_cnt)
`endif
    );

    ram_burst_reader #(.WIDTH(8), .DEPTH(200)) dut2 (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Start      (s2_start),
        .i_Start_Addr (s2_start_addr),
        .i_Length     (s2_len),
        .o_Busy       (s2_busy),
        .o_Done       (s2_done),
        .o_RAM_Addr   (s2_ram_addr),
        .i_RAM_Data   (s2_ram_q),
        .o_DV         (s2_dv),
        .o_Data       (s2_dout),
        .i_Ready      (1'b1)
`ifdef RAM_BURST_READER_STALL_CNT_EN
        ,.o_Stall_Count (s2_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_q    <= ram[ram_addr];
        s2_ram_q <= ram2[s2_ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] a, input logic [8:0] n);
        start      = 1'b1;
        start_addr = a;
        len        = n;
        step();
        start      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_b;
        logic [7:0] held;
        logic       stalled_prev;
        int         idx;
        int         stalls;
        int         cyc;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        for (int i = 0; i < 200; i++) ram2[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; len = 9'd0; ready = 1'b1;
        s2_start = 1'b0; s2_start_addr = 8'h00; s2_len = 9'd0;
        step();
        step();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_dv", dv, 1'b0);
        check_val("rst_data", dout, 8'h00);
        check_val("rst_addr", ram_addr, 8'h00);
        rst_n = 1'b1;
        step();

        // Basic burst, consumer always ready
        start_burst(8'h10, 9'd8);
        check_val("t1_busy_e0", busy, 1'b1);
        check_val("t1_addr_e0", ram_addr, 8'h10);
        check_val("t1_dv_e0", dv, 1'b0);
        step();
        check_val("t1_dv_e1", dv, 1'b0);
        check_val("t1_addr_e1", ram_addr, 8'h11);
        for (int k = 0; k < 8; k++) begin
            step();
            exp_b = 8'h10 + 8'(k);
            check_val("t1_dv", dv, 1'b1);
            check_val("t1_data", dout, exp_b);
            check_val("t1_done_low", done, 1'b0);
        end
        step();
        check_val("t1_busy_end", busy, 1'b0);
        check_val("t1_done", done, 1'b1);
        check_val("t1_dv_end", dv, 1'b0);
        step();
        check_val("t1_done_pulse", done, 1'b0);

        // Address wrap at DEPTH-1
        start_burst(8'hFE, 9'd4);
        step();
        step();
        check_val("t2_addr_wrap", ram_addr, 8'h00);
        check_val("t2_d0", dout, 8'hFE);
        step();
        check_val("t2_d1", dout, 8'hFF);
        step();
        check_val("t2_d2", dout, 8'h00);
        step();
        check_val("t2_d3", dout, 8'h01);
        step();
        check_val("t2_done", done, 1'b1);
        check_val("t2_busy", busy, 1'b0);

        // Backpressure: ready pattern 1,0,0 repeating
        start_burst(8'h20, 9'd16);
        idx = 0; stalls = 0; cyc = 0; stalled_prev = 1'b0; held = 8'h00;
        while (idx < 16 && cyc < 300) begin
            ready = (cyc % 3 == 0);
            if (stalled_prev) check_val("t3_hold", dout, held);
            check_val("t3_occ_le4", dut.u_buf.count_r <= 3'd4, 1'b1);
            if (dv && ready) begin
                exp_b = 8'h20 + 8'(idx);
                check_val("t3_order", dout, exp_b);
                idx++;
            end else if (dv) begin
                stalls++;
            end
            stalled_prev = dv && !ready;
            held = dout;
            step();
            cyc++;
        end
        ready = 1'b1;
        check_val("t3_count", idx, 16);
        check_val("t3_done", done, 1'b1);
        check_val("t3_dv_empty", dv, 1'b0);
`ifdef RAM_BURST_READER_STALL_CNT_EN
        check_val("t3_stall_cnt", stall_cnt, stalls);
`endif

        // Zero length: no RAM access, done pulse only
        start_burst(8'h80, 9'd0);
        check_val("t4_busy", busy, 1'b0);
        check_val("t4_done", done, 1'b1);
        check_val("t4_addr", ram_addr, 8'h2F);
        step();
        check_val("t4_done_pulse", done, 1'b0);
        check_val("t4_addr_hold", ram_addr, 8'h2F);

        // Second start during a burst is ignored
        start_burst(8'h40, 9'd4);
        step();
        start = 1'b1; start_addr = 8'h90; len = 9'd8;
        step();
        start = 1'b0;
        check_val("t5_d0", dout, 8'h40);
        for (int k = 1; k < 4; k++) begin
            step();
            exp_b = 8'h40 + 8'(k);
            check_val("t5_data", dout, exp_b);
        end
        step();
        check_val("t5_done", done, 1'b1);
        step();
        check_val("t5_no_restart_busy", busy, 1'b0);
        check_val("t5_no_restart_dv", dv, 1'b0);
        check_val("t5_addr", ram_addr, 8'h43);

        // Reset mid-burst after three words
        start_burst(8'h50, 9'd8);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            exp_b = 8'h50 + 8'(k);
            check_val("t6_pre_data", dout, exp_b);
        end
        step();
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", busy, 1'b0);
        check_val("t6_rst_done", done, 1'b0);
        check_val("t6_rst_dv", dv, 1'b0);
        check_val("t6_rst_data", dout, 8'h00);
        check_val("t6_rst_addr", ram_addr, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        start_burst(8'h60, 9'd2);
        step();
        step();
        check_val("t6_d0", dout, 8'h60);
        step();
        check_val("t6_d1", dout, 8'h61);
        step();
        check_val("t6_done", done, 1'b1);
        check_val("t6_dv_end", dv, 1'b0);
        step();
        check_val("t6_no_extra", dv, 1'b0);
`ifdef RAM_BURST_READER_STALL_CNT_EN
        check_val("t6_stall_cnt", stall_cnt, 16'd0);
`endif

        // Non-power-of-two depth wrap
        s2_start = 1'b1; s2_start_addr = 8'd198; s2_len = 9'd3;
        step();
        s2_start = 1'b0;
        check_val("t7_addr_e0", s2_ram_addr, 8'd198);
        step();
        step();
        check_val("t7_addr_wrap", s2_ram_addr, 8'd0);
        check_val("t7_d0", s2_dout, 8'd198);
        step();
        check_val("t7_d1", s2_dout, 8'd199);
        step();
        check_val("t7_d2", s2_dout, 8'd0);
        step();
        check_val("t7_done", s2_done, 1'b1);
        check_val("t7_busy", s2_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
